// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_gen
// Description : Program-counter generator with request/grant fetch issue,
//               in-order outstanding-address FIFO and wrong-path drop count.
//               Optional macro PC_ALIGN_CHECK_EN enables misaligned-jump flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_gen #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter int unsigned        OT_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_flag_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [2:0]        hold_flag_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              gnt_i,
  input  logic              rsp_valid_i,
  output logic              rsp_valid_o,
  output logic [ADDR_W-1:0] rsp_pc_o,
  output logic              misalign_o
);

  localparam int unsigned       PTR_W      = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
  localparam int unsigned       CNT_W      = $clog2(OT_DEPTH + 1);
  localparam int unsigned       SUM_W      = CNT_W + 1;
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(OT_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fifo_q [OT_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_drop_rsp;
  logic [SUM_W-1:0]  w_inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_flush    = jtag_reset_flag_i | jump_flag_i;
  // Dropped-but-unreturned fetches still occupy bus slots, so they gate issue.
  assign w_inflight = SUM_W'(occ_q) + SUM_W'(drop_q);

  assign req_o      = !rst && !w_flush && (hold_flag_i == 3'b000) &&
                      (w_inflight < SUM_W'(OT_DEPTH));
  assign req_addr_o = pc_q;
  assign w_push     = req_o && gnt_i;

  assign w_drop_rsp = !rst && !w_flush && rsp_valid_i && (drop_q != '0);
  assign w_pop      = !rst && !w_flush && rsp_valid_i && (drop_q == '0) && (occ_q != '0);

  assign rsp_valid_o = w_pop;
  assign rsp_pc_o    = (occ_q == '0) ? RESET_ADDR : fifo_q[rd_ptr_q];

`ifdef PC_ALIGN_CHECK_EN
  assign misalign_o = !rst && !jtag_reset_flag_i && jump_flag_i &&
                      (jump_addr_i[1:0] != 2'b00);
`else
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;

    if (jtag_reset_flag_i) begin
      pc_d = RESET_ADDR;
    end else if (jump_flag_i) begin
      pc_d = jump_addr_i & ALIGN_MASK;
    end else if (w_push) begin
      pc_d = pc_q + PC_STEP;
    end

    if (w_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      // A response arriving in the flush cycle retires one wrong-path fetch.
      if (w_inflight != '0) begin
        drop_d = CNT_W'(w_inflight - SUM_W'(rsp_valid_i));
      end else begin
        drop_d = '0;
      end
    end else begin
      if (w_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      occ_d = occ_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop_rsp) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_ADDR;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_gen
// Description : Directed self-checking bench for pc_fetch_gen (OT_DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_gen;

  logic        clk;
  logic        rst;
  logic        jtag_reset_flag_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        req_o;
  logic [31:0] req_addr_o;
  logic        gnt_i;
  logic        rsp_valid_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_pc_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  pc_fetch_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .OT_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_i       (hold_flag_i),
    .req_o             (req_o),
    .req_addr_o        (req_addr_o),
    .gnt_i             (gnt_i),
    .rsp_valid_i       (rsp_valid_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_pc_o          (rsp_pc_o),
    .misalign_o        (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jtag_reset_flag_i = 1'b0;
    jump_flag_i       = 1'b0;
    jump_addr_i       = 32'h0;
    hold_flag_i       = 3'b000;
    gnt_i             = 1'b0;
    rsp_valid_i       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Two granted fetches at 0x0 and 0x4, no responses: occ=2, pc=0x8.
  task automatic fill_two();
    gnt_i = 1'b1;
    cyc();
    cyc();
    gnt_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    #1;
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL reset_req_in_rst got=%b exp=0", req_o); end
    cyc();
    rst = 1'b0;
    #1;
    total++; if (req_o !== 1'b1) begin bad++; $display("FAIL reset_req got=%b exp=1", req_o); end
    total++; if (req_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", req_addr_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
    total++; if (rsp_pc_o !== 32'h0) begin bad++; $display("FAIL reset_rsp_pc got=%h exp=0", rsp_pc_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign_o); end
  endtask

  task automatic test_free_run();
    do_reset();
    gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rsp_valid_i = (k != 0);
      #1;
      total++; if (req_o !== 1'b1 || req_addr_o !== 32'(4 * k)) begin
        bad++; $display("FAIL free_req k=%0d got=%b/%h exp=1/%h", k, req_o, req_addr_o, 32'(4 * k));
      end
      if (k != 0) begin
        total++; if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'(4 * (k - 1))) begin
          bad++; $display("FAIL free_rsp k=%0d got=%b/%h exp=1/%h", k, rsp_valid_o, rsp_pc_o, 32'(4 * (k - 1)));
        end
      end
      cyc();
    end
  endtask

  task automatic test_fill();
    do_reset();
    gnt_i = 1'b1;
    #1;
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h0) begin bad++; $display("FAIL fill_g0 got=%b/%h exp=1/0", req_o, req_addr_o); end
    cyc();
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h4) begin bad++; $display("FAIL fill_g1 got=%b/%h exp=1/4", req_o, req_addr_o); end
    cyc();
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", req_o); end
    cyc();
    rsp_valid_i = 1'b1;
    #1;
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL fill_full_rsp got=%b exp=0", req_o); end
    total++; if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h0) begin bad++; $display("FAIL fill_rsp got=%b/%h exp=1/0", rsp_valid_o, rsp_pc_o); end
    cyc();
    rsp_valid_i = 1'b0;
    #1;
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h8) begin bad++; $display("FAIL fill_resume got=%b/%h exp=1/8", req_o, req_addr_o); end
    total++; if (rsp_pc_o !== 32'h4) begin bad++; $display("FAIL fill_head got=%h exp=4", rsp_pc_o); end
  endtask

  task automatic test_jump();
    do_reset();
    fill_two();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    rsp_valid_i = 1'b1;
    gnt_i       = 1'b1;
    #1;
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL jump_req got=%b exp=0", req_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL jump_rsp got=%b exp=0", rsp_valid_o); end
    cyc();
    jump_flag_i = 1'b0;
    #1;
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL jump_drop got=%b exp=0", rsp_valid_o); end
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h100) begin bad++; $display("FAIL jump_target got=%b/%h exp=1/100", req_o, req_addr_o); end
    cyc();
    gnt_i = 1'b0;
    #1;
    total++; if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h100) begin bad++; $display("FAIL jump_fwd got=%b/%h exp=1/100", rsp_valid_o, rsp_pc_o); end
    total++; if (req_addr_o !== 32'h104) begin bad++; $display("FAIL jump_next got=%h exp=104", req_addr_o); end
  endtask

  task automatic test_hold();
    do_reset();
    gnt_i = 1'b1;
    cyc();
    hold_flag_i = 3'b001;
    for (int k = 0; k < 3; k++) begin
      rsp_valid_i = (k == 1);
      #1;
      total++; if (req_o !== 1'b0 || req_addr_o !== 32'h4) begin
        bad++; $display("FAIL hold_req k=%0d got=%b/%h exp=0/4", k, req_o, req_addr_o);
      end
      if (k == 1) begin
        total++; if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'h0) begin
          bad++; $display("FAIL hold_rsp got=%b/%h exp=1/0", rsp_valid_o, rsp_pc_o);
        end
      end
      cyc();
    end
    hold_flag_i = 3'b000;
    rsp_valid_i = 1'b0;
    #1;
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h4) begin bad++; $display("FAIL hold_resume got=%b/%h exp=1/4", req_o, req_addr_o); end
  endtask

  task automatic test_jtag();
    do_reset();
    fill_two();
    hold_flag_i       = 3'b001;
    jtag_reset_flag_i = 1'b1;
    jump_flag_i       = 1'b1;
    jump_addr_i       = 32'h200;
    cyc();
    jtag_reset_flag_i = 1'b0;
    jump_flag_i       = 1'b0;
    hold_flag_i       = 3'b000;
    rsp_valid_i       = 1'b1;
    #1;
    total++; if (req_addr_o !== 32'h0) begin bad++; $display("FAIL jtag_pc got=%h exp=0", req_addr_o); end
    total++; if (req_o !== 1'b0 || rsp_valid_o !== 1'b0) begin bad++; $display("FAIL jtag_drop0 got=%b/%b exp=0/0", req_o, rsp_valid_o); end
    cyc();
    #1;
    total++; if (req_o !== 1'b1 || rsp_valid_o !== 1'b0) begin bad++; $display("FAIL jtag_drop1 got=%b/%b exp=1/0", req_o, rsp_valid_o); end
    cyc();
    // Stray response with nothing in flight must be ignored.
    #1;
    total++; if (rsp_valid_o !== 1'b0 || rsp_pc_o !== 32'h0) begin bad++; $display("FAIL jtag_stray got=%b/%h exp=0/0", rsp_valid_o, rsp_pc_o); end
    cyc();
    rsp_valid_i = 1'b0;
    #1;
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h0) begin bad++; $display("FAIL jtag_after got=%b/%h exp=1/0", req_o, req_addr_o); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    fill_two();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_valid_i = 1'b1;
    #1;
    total++; if (req_o !== 1'b1 || req_addr_o !== 32'h0) begin bad++; $display("FAIL rst_mid_req got=%b/%h exp=1/0", req_o, req_addr_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_rsp got=%b exp=0", rsp_valid_o); end
  endtask

  task automatic test_misalign();
    logic exp_mis;
`ifdef PC_ALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    do_reset();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h102;
    #1;
    total++; if (misalign_o !== exp_mis) begin bad++; $display("FAIL mis_pulse got=%b exp=%b", misalign_o, exp_mis); end
    cyc();
    jump_flag_i = 1'b0;
    #1;
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misalign_o); end
    total++; if (req_addr_o !== 32'h100) begin bad++; $display("FAIL mis_addr got=%h exp=100", req_addr_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    cyc();
    jump_flag_i = 1'b0;
    gnt_i       = 1'b1;
    cyc();
    gnt_i = 1'b0;
    #1;
    total++; if (req_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", req_addr_o); end
    rsp_valid_i = 1'b1;
    #1;
    total++; if (rsp_valid_o !== 1'b1 || rsp_pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_rsp got=%b/%h exp=1/fffffffc", rsp_valid_o, rsp_pc_o); end
    cyc();
    rsp_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_free_run();
    test_fill();
    test_jump();
    test_hold();
    test_jtag();
    test_rst_mid();
    test_misalign();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
